// File: rtl/sram_burst_reader.sv
// sram_burst_reader: burst read initiator for the sram_corex family.
// Issues one word read per OE cycle, absorbs the SRAM's one-cycle read
// latency through an in-flight flag, and buffers returned words in a
// 2-entry FIFO that feeds a valid/ready stream with full back-pressure.
module sram_burst_reader #(
    parameter int unsigned address_width = 22,
    parameter int unsigned data_width    = 2,
    parameter int unsigned count_width   = 16
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  START,
    input  logic [address_width-1:0]              BASE_ADDR,
    input  logic [count_width-1:0]                LENGTH,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic [address_width-1:0]              SRAM_READ_ADDR,
    output logic                                  SRAM_OE,
    input  logic [(1 << data_width)*8-1:0]        SRAM_DATA,
    output logic [(1 << data_width)*8-1:0]        M_DATA,
    output logic                                  M_VALID,
    input  logic                                  M_READY,
    output logic                                  M_LAST
);

    localparam int unsigned DW = (1 << data_width) * 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [count_width-1:0]   len_q, len_d;
    logic [count_width-1:0]   issued_q, issued_d;
    logic [count_width-1:0]   delivered_q, delivered_d;
    logic                     inflight_q, inflight_d;
    logic [DW-1:0]            fifo_q [2];
    logic [DW-1:0]            fifo_d [2];
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic [1:0]               count_q, count_d;

    logic                     pop;
    logic                     push;
    logic                     issue;
    logic                     last_word;
    logic [2:0]               occupancy;

    // Stream handshake, credit accounting and the read-issue decision.
    always_comb begin
        pop       = (count_q != 2'd0) && M_READY;
        push      = inflight_q;
        last_word = (delivered_q == (len_q - count_width'(1)));
        // Words already buffered or in flight, minus the one leaving now;
        // a new read is only issued if it is guaranteed a FIFO slot.
        occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == ST_READ) && (issued_q < len_q) && (occupancy < 3'd2);
    end

    // Next-state logic for the burst FSM, address/length counters and FIFO.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = issue;
        fifo_d      = fifo_q;
        rd_ptr_d    = rd_ptr_q ^ pop;
        wr_ptr_d    = wr_ptr_q ^ push;
        count_d     = count_q + 2'(push) - 2'(pop);

        if (push) begin
            fifo_d[wr_ptr_q] = SRAM_DATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    addr_d      = BASE_ADDR;
                    len_d       = LENGTH;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (LENGTH != '0) ? ST_READ : ST_FINISH;
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d   = addr_q + address_width'(1);
                    issued_d = issued_q + count_width'(1);
                end
                if (pop) begin
                    delivered_d = delivered_q + count_width'(1);
                    if (last_word) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset also drops any in-flight read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fifo_q      <= fifo_d;
        end
    end

    // Outputs are decoded from registered state only (OE via the credit check).
    always_comb begin
        BUSY           = (state_q == ST_READ);
        DONE           = (state_q == ST_FINISH);
        SRAM_OE        = issue;
        SRAM_READ_ADDR = addr_q;
        M_VALID        = (count_q != 2'd0);
        M_DATA         = fifo_q[rd_ptr_q];
        M_LAST         = M_VALID && last_word && (state_q == ST_READ);
    end

endmodule
